// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - FC-layer sequencer: clear, stream addresses, capture outputs, signed argmax
// Optional feature macro: SEQ_ABORT_EN (adds the abort input)
module layer_sequencer #(
   parameter int N_INPUTS  = 784,
   parameter int N_NEURONS = 10,
   parameter int ADDR_W    = 10,
   parameter int IDX_W     = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
`ifdef SEQ_ABORT_EN
   input  logic                     abort,
`endif
   output logic                     busy,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic                     nrn_clear,
   output logic                     nrn_inp_ready,
   input  logic                     nrn_out_ready,
   input  logic [16*N_NEURONS-1:0]  nrn_out,
   output logic [IDX_W-1:0]         result_idx,
   output logic signed [15:0]       result_val,
   output logic                     done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_NEURONS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_STREAM,
      S_WAIT_OUT,
      S_ARGMAX,
      S_DONE
   } state_t;

   state_t                 state;
   state_t                 next_state;
   logic [ADDR_W-1:0]      addr_q;
   logic                   inp_q;
   logic                   done_q;
   logic signed [15:0]     cap [N_NEURONS];
   logic [IDX_W-1:0]       scan_idx;
   logic signed [15:0]     best_val;
   logic [IDX_W-1:0]       best_idx;
   logic                   abort_hit;

`ifdef SEQ_ABORT_EN
   assign abort_hit = abort && (state != S_IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // next-state decode and the combinational neuron clear
   always_comb begin
      next_state = state;
      nrn_clear  = 1'b0;
      case (state)
         S_IDLE: begin
            // the done cycle still reads as busy, so a start there is not taken
            if (start && !done_q) begin
               next_state = S_CLEAR;
            end
         end
         S_CLEAR: begin
            nrn_clear  = 1'b1;
            next_state = S_STREAM;
         end
         S_STREAM: begin
            if (addr_q == LAST_ADDR) begin
               next_state = S_WAIT_OUT;
            end
         end
         S_WAIT_OUT: begin
            if (nrn_out_ready) begin
               next_state = S_ARGMAX;
            end
         end
         S_ARGMAX: begin
            if (scan_idx == LAST_IDX) begin
               next_state = S_DONE;
            end
         end
         S_DONE: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
      // an abort leaves the neurons cleared so a partial sum never lingers
      if (abort_hit) begin
         next_state = S_IDLE;
         nrn_clear  = 1'b1;
      end
   end

   // address counter and the input strobe, which trails each address by one cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q <= '0;
         inp_q  <= 1'b0;
      end else begin
         inp_q <= (state == S_STREAM) && !abort_hit;
         if ((state == S_STREAM) && (addr_q != LAST_ADDR) && !abort_hit) begin
            addr_q <= addr_q + 1'b1;
         end else begin
            addr_q <= '0;
         end
      end
   end

   // capture every neuron output on the completion strobe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < N_NEURONS; k++) begin
            cap[k] <= '0;
         end
      end else if ((state == S_WAIT_OUT) && nrn_out_ready && !abort_hit) begin
         for (int k = 0; k < N_NEURONS; k++) begin
            cap[k] <= nrn_out[16*k +: 16];
         end
      end
   end

   // sequential argmax: slot 0 seeds the best, later slots replace it only when strictly larger
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_idx <= '0;
         best_val <= '0;
         best_idx <= '0;
      end else if (state == S_ARGMAX) begin
         if (scan_idx == '0) begin
            best_val <= cap[0];
            best_idx <= '0;
         end else if (cap[scan_idx] > best_val) begin
            best_val <= cap[scan_idx];
            best_idx <= scan_idx;
         end
         scan_idx <= scan_idx + 1'b1;
      end else begin
         scan_idx <= '0;
      end
   end

   // publish the result together with the done pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_q     <= 1'b0;
         result_idx <= '0;
         result_val <= '0;
      end else begin
         done_q <= (state == S_DONE) && !abort_hit;
         if ((state == S_DONE) && !abort_hit) begin
            result_idx <= best_idx;
            result_val <= best_val;
         end
      end
   end

   assign busy          = (state != S_IDLE) || done_q;
   assign done          = done_q;
   assign mem_addr      = addr_q;
   assign nrn_inp_ready = inp_q && !abort_hit;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - randomized self-checking bench for layer_sequencer
module tb_layer_sequencer;

   localparam int N_INPUTS  = 784;
   localparam int N_NEURONS = 10;
   localparam int ADDR_W    = 10;
   localparam int IDX_W     = 4;
   localparam int LATENCY   = N_INPUTS + N_NEURONS + 4;

   logic                    clk = 1'b0;
   logic                    reset = 1'b0;
   logic                    start = 1'b0;
`ifdef SEQ_ABORT_EN
   logic                    abort = 1'b0;
`endif
   logic                    busy;
   logic [ADDR_W-1:0]       mem_addr;
   logic                    nrn_clear;
   logic                    nrn_inp_ready;
   logic                    nrn_out_ready = 1'b0;
   logic [16*N_NEURONS-1:0] nrn_out = '0;
   logic [IDX_W-1:0]        result_idx;
   logic [15:0]             result_val;
   logic                    done;

   layer_sequencer #(
      .N_INPUTS  (N_INPUTS),
      .N_NEURONS (N_NEURONS),
      .ADDR_W    (ADDR_W),
      .IDX_W     (IDX_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
`ifdef SEQ_ABORT_EN
      .abort         (abort),
`endif
      .busy          (busy),
      .mem_addr      (mem_addr),
      .nrn_clear     (nrn_clear),
      .nrn_inp_ready (nrn_inp_ready),
      .nrn_out_ready (nrn_out_ready),
      .nrn_out       (nrn_out),
      .result_idx    (result_idx),
      .result_val    (result_val),
      .done          (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   // free-running cycle count, one per rising edge
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] img_vals [N_NEURONS];
   int          last_idx = 0;
   logic [15:0] last_val = '0;

   // neuron array model: counts strobes since the last clear and fires one cycle after the last one
   int  mcnt = 0;
   bit  arm  = 0;
   always @(negedge clk) begin
      nrn_out_ready = 1'b0;
      for (int k = 0; k < N_NEURONS; k++) nrn_out[16*k +: 16] = 16'($urandom);
      if (!reset) begin
         mcnt = 0;
         arm  = 0;
      end else begin
         if (arm) begin
            nrn_out_ready = 1'b1;
            for (int k = 0; k < N_NEURONS; k++) nrn_out[16*k +: 16] = img_vals[k];
            arm = 0;
         end
         if (nrn_clear) begin
            mcnt = 0;
         end else if (nrn_inp_ready) begin
            mcnt++;
            if (mcnt == N_INPUTS) arm = 1;
         end
      end
   end

   // observation counters for the current run
   int clear_cnt, strobe_cnt, addr_err, gap_err, done_cnt, busy_drop;
   bit in_run = 0;
   logic [ADDR_W-1:0] prev_addr = '0;
   logic prev_inp = 1'b0;
   always @(negedge clk) begin
      if (nrn_clear) clear_cnt++;
      if (done) done_cnt++;
      if (in_run && !busy) busy_drop++;
      if (nrn_inp_ready && !prev_inp && strobe_cnt != 0) gap_err++;
      if (!nrn_inp_ready && prev_inp && strobe_cnt != N_INPUTS) gap_err++;
      if (nrn_inp_ready) begin
         if (int'(prev_addr) != strobe_cnt) addr_err++;
         strobe_cnt++;
      end
      prev_addr = mem_addr;
      prev_inp  = nrn_inp_ready;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_counters();
      clear_cnt = 0; strobe_cnt = 0; addr_err = 0; gap_err = 0; done_cnt = 0; busy_drop = 0;
   endtask

   task automatic random_image();
      for (int k = 0; k < N_NEURONS; k++) img_vals[k] = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
         img_vals[$urandom_range(0, N_NEURONS-1)] = 16'h7FFF;
         img_vals[$urandom_range(0, N_NEURONS-1)] = 16'h7FFF;
      end
   endtask

   task automatic run_image(input string tag, input bit repulse);
      int          exp_i;
      logic [15:0] exp_v;
      int          t0;
      int          lat;
      bit          got;
      exp_v = img_vals[0];
      for (int k = 1; k < N_NEURONS; k++)
         if ($signed(img_vals[k]) > $signed(exp_v)) exp_v = img_vals[k];
      exp_i = -1;
      for (int k = 0; k < N_NEURONS; k++)
         if (exp_i < 0 && img_vals[k] == exp_v) exp_i = k;

      clear_counters();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      t0     = cyc;
      in_run = 1;
      got    = 0;
      lat    = 0;
      for (int k = 1; k <= 2000 && !got; k++) begin
         start = repulse && (k == 10 || k == 500);
         @(negedge clk);
         if (done) begin
            got = 1;
            lat = cyc - t0;
            check({tag, "_idx"}, 32'(result_idx), 32'(exp_i));
            check({tag, "_val"}, 32'(result_val), 32'(exp_v));
         end
      end
      start  = 1'b0;
      in_run = 0;
      check({tag, "_done_seen"}, 32'(got), 32'd1);
      check({tag, "_latency"}, 32'(lat), 32'(LATENCY));
      check({tag, "_clear_cycles"}, 32'(clear_cnt), 32'd1);
      check({tag, "_strobes"}, 32'(strobe_cnt), 32'(N_INPUTS));
      check({tag, "_addr_seq_errs"}, 32'(addr_err), 32'd0);
      check({tag, "_strobe_gaps"}, 32'(gap_err), 32'd0);
      check({tag, "_busy_drops"}, 32'(busy_drop), 32'd0);
      repeat (3) @(negedge clk);
      check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
      check({tag, "_addr_after"}, 32'(mem_addr), 32'd0);
      last_idx = exp_i;
      last_val = exp_v;
   endtask

   task automatic wait_addr(input string tag, input int target);
      bit found;
      found = 0;
      for (int k = 0; k < 2000 && !found; k++) begin
         @(negedge clk);
         if (int'(mem_addr) == target) found = 1;
      end
      check({tag, "_reached_addr"}, 32'(found), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < N_NEURONS; k++) img_vals[k] = '0;
      clear_counters();
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_clear", 32'(nrn_clear), 0);
      check("rst_inp", 32'(nrn_inp_ready), 0);
      check("rst_addr", 32'(mem_addr), 0);
      check("rst_idx", 32'(result_idx), 0);
      check("rst_val", 32'(result_val), 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      img_vals[0] = 16'h0100; img_vals[1] = 16'h0300; img_vals[2] = 16'hFF00; img_vals[3] = 16'h0280;
      run_image("basic", 0);

      img_vals[0] = 16'hFF80; img_vals[1] = 16'hFE00; img_vals[2] = 16'hFF10;
      for (int k = 3; k < N_NEURONS; k++) img_vals[k] = 16'h8000;
      run_image("negative", 0);

      for (int k = 0; k < N_NEURONS; k++) img_vals[k] = 16'(k * 16);
      img_vals[3] = 16'h0500; img_vals[7] = 16'h0500;
      run_image("tie", 0);

      random_image();
      run_image("repulse", 1);

      for (int r = 0; r < 4; r++) begin
         random_image();
         run_image("random", 0);
      end

`ifdef SEQ_ABORT_EN
      random_image();
      clear_counters();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_addr("abort", 400);
      abort = 1'b1;
      #1;
      check("abort_clear", 32'(nrn_clear), 1);
      check("abort_inp", 32'(nrn_inp_ready), 0);
      @(negedge clk);
      abort = 1'b0;
      check("abort_idle", 32'(busy), 0);
      repeat (5) @(negedge clk);
      check("abort_no_done", 32'(done_cnt), 0);
      check("abort_idx_held", 32'(result_idx), 32'(last_idx));
      check("abort_val_held", 32'(result_val), 32'(last_val));
`endif

      random_image();
      clear_counters();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_addr("midrst", 400);
      reset = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 0);
      check("midrst_addr", 32'(mem_addr), 0);
      check("midrst_inp", 32'(nrn_inp_ready), 0);
      check("midrst_clear", 32'(nrn_clear), 0);
      check("midrst_idx", 32'(result_idx), 0);
      check("midrst_val", 32'(result_val), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check("midrst_no_done", 32'(done_cnt), 0);
      random_image();
      run_image("after_rst", 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Controls one fully-connected layer of identical Q8.8 MAC neurons that run in lockstep.
- Per image: clears the neurons, then streams N_INPUTS pixel/weight addresses to the pixel RAM and the per-neuron weight ROMs, pulsing the neurons' input strobe.
- Captures all neuron outputs when they complete, runs a sequential signed argmax and reports the winning class.
- Sits between the image-load logic (start/done) and the neuron array.

Parameters:
N_INPUTS, 784, pixels per image (= MAC steps per neuron)
N_NEURONS, 10, neurons in the layer (output classes)
ADDR_W, 10, pixel/weight address width, must satisfy 2**ADDR_W >= N_INPUTS
IDX_W, 4, class-index width, must satisfy 2**IDX_W >= N_NEURONS

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to classify the image currently in pixel RAM
busy  out  1  high from the cycle after start is accepted through the done cycle
mem_addr  out  ADDR_W  shared read address to pixel RAM and all weight ROMs (1-cycle read latency)
nrn_clear  out  1  synchronous active-high clear to all neurons (drives their reset input)
nrn_inp_ready  out  1  input-valid strobe to all neurons, aligned with RAM/ROM read data
nrn_out_ready  in  1  completion strobe from neuron 0 (all neurons are in lockstep)
nrn_out  in  16*N_NEURONS  packed signed Q8.8 neuron outputs, neuron k at [16k+15:16k]
result_idx  out  IDX_W  index of the largest neuron output
result_val  out  16  signed Q8.8 value of that output
done  out  1  single-cycle pulse; result_idx and result_val are valid from this cycle

Behaviour:
- Reset (reset=0, asynchronous): state IDLE.
  - busy=0, done=0, nrn_clear=0, nrn_inp_ready=0, mem_addr=0, result_idx=0, result_val=0.
  - Internal counters and capture registers are cleared.
- IDLE: start=1 → CLEAR. start is ignored in every other state; it is neither queued nor does it restart.
- CLEAR: nrn_clear=1 for exactly one cycle, mem_addr=0 → STREAM.
- STREAM:
  - mem_addr steps 0,1,…,N_INPUTS-1, one per cycle.
  - nrn_inp_ready is registered and asserted the cycle after each address is issued, giving exactly N_INPUTS contiguous strobes.
  - After address N_INPUTS-1 is issued → WAIT_OUT. mem_addr returns to 0 and holds there.
- WAIT_OUT: wait for nrn_out_ready=1, then capture all N_NEURONS words of nrn_out into an internal register file → ARGMAX.
  - No timeout; the state waits indefinitely.
  - nrn_out_ready seen in any other state is ignored.
- ARGMAX:
  - Initialise best = entry 0, best_idx = 0.
  - Examine entries 1..N_NEURONS-1, one per cycle.
  - Replace best only when entry > best, using a signed 16-bit compare. Ties keep the lower index.
  - Occupies N_NEURONS cycles → DONE.
- DONE: done=1 for one cycle, result_idx/result_val updated on that edge → IDLE.
  - result_idx/result_val hold until the next done.
  - busy drops the cycle after done.
- Latency: with a neuron whose out_ready follows its last input by one cycle, done asserts N_INPUTS+N_NEURONS+4 cycles after the edge that samples start (798 at the defaults).
- The capture registers are updated only in WAIT_OUT; the previous image's capture is never reused.
- Reset asserted mid-operation: immediate return to IDLE, no done pulse, result outputs cleared to 0.
- N_NEURONS=1: ARGMAX takes 1 cycle and result_idx=0.

Optional Feature:
SEQ_ABORT_EN
- Defined: adds input port abort (1 bit).
  - abort=1 in any non-IDLE state: next state is IDLE, nrn_clear=1 for that one cycle, nrn_inp_ready=0, no done pulse, result outputs unchanged.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: start wins.
- Not defined: no abort port, no abort logic.

Test Plan:
- Reset then single start, neuron model outputs {0x0100,0x0300,0xFF00,0x0280,…0} → nrn_clear one cycle; 784 contiguous nrn_inp_ready; mem_addr 0..783; done at cycle 798; result_idx=1, result_val=0x0300.
- All outputs negative {0xFF80,0xFE00,0xFF10,…all 0x8000} → result_idx=0, result_val=0xFF80 (signed compare).
- Tie: outputs 3 and 7 both 0x0500 and the maximum → result_idx=3.
- start re-pulsed at cycles 10 and 500 during STREAM → ignored, exactly one done; busy stays 1 throughout; mem_addr sequence undisturbed.
- Two back-to-back images with different outputs → second result reflects only the second capture; nrn_clear pulses before each stream.
- reset driven low at mem_addr=400, released, then start → outputs 0 during reset, no done; clean full run afterwards (with SEQ_ABORT_EN: abort at mem_addr=400 → IDLE, nrn_clear pulse, prior result held).
